// File: rtl/pr_slot_freeze_pkg.sv
// Shared definitions for the PR-slot freeze gate: state encoding, drop-counter width
// and the saturating increment used by the drain counter.
package pr_slot_freeze_pkg;

  localparam int unsigned DROP_CNT_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_WAIT_EOP = 2'd1;
  localparam state_t ST_ABORT    = 2'd2;
  localparam state_t ST_FROZEN   = 2'd3;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    if (v == {DROP_CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + DROP_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/pcie_ss_axis_if.sv
// AXI-Stream bundle used on both sides of the PR-slot freeze gate.
interface pcie_ss_axis_if #(
  parameter int DATA_W = 64,
  parameter int USER_W = 10
);
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [USER_W-1:0] tuser_vendor;
  logic [DATA_W-1:0] tdata;
  logic [DATA_W/8-1:0] tkeep;

  modport sink   (input tvalid, tlast, tuser_vendor, tdata, tkeep, output tready);
  modport source (output tvalid, tlast, tuser_vendor, tdata, tkeep, input tready);
endinterface

// File: rtl/pr_slot_freeze_eop_gate.sv
// Freezes a stream at a packet boundary for partial reconfiguration, force-terminating
// a stalled packet after TIMEOUT_CYCLES. Define PR_FREEZE_DRAIN_EN to discard upstream beats while frozen.
module pr_slot_freeze_eop_gate
  import pr_slot_freeze_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pr_freeze,
  pcie_ss_axis_if.sink          axis_snk_if,
  pcie_ss_axis_if.source        axis_src_if,
  output logic                  freeze_ack,
  output logic                  eop_timeout,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

`ifdef PR_FREEZE_DRAIN_EN
  localparam logic FROZEN_READY = 1'b1;
`else
  localparam logic FROZEN_READY = 1'b0;
`endif

  state_t      r_state;
  logic        r_in_pkt;
  logic [15:0] r_wait_cnt;
  logic        r_eop_timeout;

  state_t      w_state_nxt;
  logic        w_in_pkt_nxt;
  logic [15:0] w_wait_cnt_nxt;
  logic        w_eop_timeout_nxt;
  logic        w_pass;
  logic        w_accept;
  logic        w_in_pkt_upd;

  assign w_pass       = (r_state == ST_RUN) || (r_state == ST_WAIT_EOP);
  assign w_accept     = w_pass && !rst && axis_snk_if.tvalid && axis_src_if.tready;
  assign w_in_pkt_upd = w_accept ? !axis_snk_if.tlast : r_in_pkt;

  // Stream muxing: pass-through, synthetic terminating beat, or blocked.
  always_comb begin
    axis_src_if.tvalid       = 1'b0;
    axis_src_if.tlast        = axis_snk_if.tlast;
    axis_src_if.tdata        = axis_snk_if.tdata;
    axis_src_if.tkeep        = axis_snk_if.tkeep;
    axis_src_if.tuser_vendor = axis_snk_if.tuser_vendor;
    axis_snk_if.tready       = 1'b0;
    if (rst) begin
      axis_src_if.tvalid = 1'b0;
      axis_snk_if.tready = 1'b0;
    end else begin
      case (r_state)
        ST_RUN, ST_WAIT_EOP: begin
          axis_src_if.tvalid = axis_snk_if.tvalid;
          axis_snk_if.tready = axis_src_if.tready;
        end
        ST_ABORT: begin
          axis_src_if.tvalid       = 1'b1;
          axis_src_if.tlast        = 1'b1;
          axis_src_if.tdata        = '0;
          axis_src_if.tkeep        = '0;
          axis_src_if.tuser_vendor = '0;
          axis_snk_if.tready       = 1'b0;
        end
        ST_FROZEN: begin
          axis_src_if.tvalid = 1'b0;
          axis_snk_if.tready = FROZEN_READY;
        end
        default: begin
          axis_src_if.tvalid = 1'b0;
          axis_snk_if.tready = 1'b0;
        end
      endcase
    end
  end

  // Next-state, packet tracking and EOP wait timer.
  always_comb begin
    w_state_nxt       = r_state;
    w_in_pkt_nxt      = w_in_pkt_upd;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_eop_timeout_nxt = r_eop_timeout;
    case (r_state)
      ST_RUN: begin
        w_wait_cnt_nxt = 16'd0;
        if (pr_freeze) begin
          w_state_nxt = w_in_pkt_upd ? ST_WAIT_EOP : ST_FROZEN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_WAIT_EOP: begin
        if (w_accept && axis_snk_if.tlast) begin
          w_state_nxt = ST_FROZEN;
        end else if (!pr_freeze) begin
          w_state_nxt = ST_RUN;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_state_nxt       = ST_ABORT;
          w_eop_timeout_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 16'd1;
        end
      end
      ST_ABORT: begin
        // The synthetic beat is always delivered, even if the freeze request is withdrawn.
        if (axis_src_if.tready) begin
          w_state_nxt  = ST_FROZEN;
          w_in_pkt_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_ABORT;
        end
      end
      ST_FROZEN: begin
        w_in_pkt_nxt = 1'b0;
        if (!pr_freeze) begin
          w_state_nxt       = ST_RUN;
          w_eop_timeout_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_FROZEN;
        end
      end
      default: begin
        w_state_nxt  = ST_RUN;
        w_in_pkt_nxt = 1'b0;
      end
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_in_pkt      <= 1'b0;
      r_wait_cnt    <= 16'd0;
      r_eop_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_in_pkt      <= w_in_pkt_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_eop_timeout <= w_eop_timeout_nxt;
    end
  end

  assign freeze_ack  = (r_state == ST_FROZEN) && !rst;
  assign eop_timeout = r_eop_timeout;

`ifdef PR_FREEZE_DRAIN_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  // Saturating count of beats discarded while frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if ((r_state == ST_FROZEN) && axis_snk_if.tvalid) begin
      r_drop_cnt <= sat_inc(r_drop_cnt);
    end else begin
      r_drop_cnt <= r_drop_cnt;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pr_slot_freeze_eop_gate.sv
// Scoreboard bench for pr_slot_freeze_eop_gate (TIMEOUT_CYCLES=16); honours PR_FREEZE_DRAIN_EN.
module tb_pr_slot_freeze_eop_gate;

`ifdef PR_FREEZE_DRAIN_EN
  localparam bit DRAIN = 1'b1;
`else
  localparam bit DRAIN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pr_freeze = 1'b0;
  logic        freeze_ack;
  logic        eop_timeout;
  logic [15:0] drop_cnt;

  pcie_ss_axis_if #(.DATA_W(64), .USER_W(10)) snk_if ();
  pcie_ss_axis_if #(.DATA_W(64), .USER_W(10)) src_if ();

  pr_slot_freeze_eop_gate #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .pr_freeze   (pr_freeze),
    .axis_snk_if (snk_if),
    .axis_src_if (src_if),
    .freeze_ack  (freeze_ack),
    .eop_timeout (eop_timeout),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [82:0] exp_q[$];
  logic [82:0] synth_beat;
  logic [15:0] exp_drop;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic last);
    int  n;
    bit  acc;
    snk_if.tvalid       = 1'b1;
    snk_if.tdata        = d;
    snk_if.tkeep        = 8'hFF;
    snk_if.tlast        = last;
    snk_if.tuser_vendor = d[9:0];
    exp_q.push_back({last, d[9:0], 8'hFF, d});
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = (snk_if.tready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    chk("beat_accept", 96'(acc), 96'(1));
    snk_if.tvalid = 1'b0;
  endtask

  // Output monitor: every downstream handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (src_if.tvalid === 1'b1 && src_if.tready === 1'b1) begin
      chk("out_expected", 96'(exp_q.size() != 0), 96'(1));
      if (exp_q.size() != 0) begin
        chk("out_beat", 96'({src_if.tlast, src_if.tuser_vendor, src_if.tkeep, src_if.tdata}),
            96'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    synth_beat = {1'b1, 10'd0, 8'd0, 64'd0};
    exp_drop   = 16'd0;
    snk_if.tvalid       = 1'b1;
    snk_if.tlast        = 1'b0;
    snk_if.tdata        = 64'h1234;
    snk_if.tkeep        = 8'hFF;
    snk_if.tuser_vendor = 10'd5;
    src_if.tready       = 1'b1;

    // Reset state
    tick(3);
    chk("rst_src_tvalid", 96'(src_if.tvalid), 96'(0));
    chk("rst_snk_tready", 96'(snk_if.tready), 96'(0));
    chk("rst_freeze_ack", 96'(freeze_ack), 96'(0));
    snk_if.tvalid = 1'b0;
    rst = 1'b0;
    tick(1);
    chk("post_rst_ack", 96'(freeze_ack), 96'(0));
    chk("post_rst_timeout", 96'(eop_timeout), 96'(0));
    chk("post_rst_drop", 96'(drop_cnt), 96'(0));

    // Idle freeze: ack one cycle after request
    tick(6);
    pr_freeze = 1'b1;
    chk("idle_ack_same_cycle", 96'(freeze_ack), 96'(0));
    tick(1);
    chk("idle_ack", 96'(freeze_ack), 96'(1));
    snk_if.tvalid = 1'b1;
    snk_if.tdata  = 64'hDEAD;
    chk("frozen_src_tvalid", 96'(src_if.tvalid), 96'(0));
    chk("frozen_snk_tready", 96'(snk_if.tready), 96'(DRAIN));
    tick(1);
    snk_if.tvalid = 1'b0;
    if (DRAIN) exp_drop = exp_drop + 16'd1;
    chk("frozen_drop", 96'(drop_cnt), 96'(exp_drop));
    pr_freeze = 1'b0;
    tick(1);
    chk("unfreeze_ack", 96'(freeze_ack), 96'(0));

    // 4-beat packet, freeze raised after beat 2
    drive_beat(64'hA001, 1'b0);
    drive_beat(64'hA002, 1'b0);
    pr_freeze = 1'b1;
    tick(1);
    chk("wait_ack", 96'(freeze_ack), 96'(0));
    drive_beat(64'hA003, 1'b0);
    chk("wait_ack_b3", 96'(freeze_ack), 96'(0));
    drive_beat(64'hA004, 1'b1);
    chk("eop_ack", 96'(freeze_ack), 96'(1));
    chk("eop_no_timeout", 96'(eop_timeout), 96'(0));
    pr_freeze = 1'b0;
    tick(1);
    chk("eop_release", 96'(freeze_ack), 96'(0));

    // Stalled packet: timeout, held synthetic beat, then freeze
    drive_beat(64'hB001, 1'b0);
    pr_freeze = 1'b1;
    tick(1);
    src_if.tready = 1'b0;
    tick(15);
    chk("wait15_ack", 96'(freeze_ack), 96'(0));
    chk("wait15_tvalid", 96'(src_if.tvalid), 96'(0));
    chk("wait15_timeout", 96'(eop_timeout), 96'(0));
    tick(1);
    chk("abort_timeout", 96'(eop_timeout), 96'(1));
    snk_if.tvalid = 1'b1;
    snk_if.tdata  = 64'hBEEF;
    snk_if.tlast  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("abort_tvalid", 96'(src_if.tvalid), 96'(1));
      chk("abort_beat", 96'({src_if.tlast, src_if.tuser_vendor, src_if.tkeep, src_if.tdata}),
          96'(synth_beat));
      chk("abort_snk_tready", 96'(snk_if.tready), 96'(0));
      chk("abort_ack", 96'(freeze_ack), 96'(0));
      tick(1);
    end
    snk_if.tvalid = 1'b0;
    exp_q.push_back(synth_beat);
    src_if.tready = 1'b1;
    tick(1);
    chk("abort_done_ack", 96'(freeze_ack), 96'(1));
    chk("abort_done_timeout", 96'(eop_timeout), 96'(1));
    chk("abort_done_tvalid", 96'(src_if.tvalid), 96'(0));
    pr_freeze = 1'b0;
    tick(1);
    chk("timeout_cleared", 96'(eop_timeout), 96'(0));
    pr_freeze = 1'b1;
    tick(1);
    chk("abort_cleared_inpkt", 96'(freeze_ack), 96'(1));
    pr_freeze = 1'b0;
    tick(1);

    // Freeze withdrawn during WAIT_EOP keeps the open packet
    drive_beat(64'hC001, 1'b0);
    pr_freeze = 1'b1;
    tick(4);
    pr_freeze = 1'b0;
    tick(1);
    chk("withdraw_ack", 96'(freeze_ack), 96'(0));
    chk("withdraw_timeout", 96'(eop_timeout), 96'(0));
    pr_freeze = 1'b1;
    tick(1);
    chk("withdraw_inpkt_kept", 96'(freeze_ack), 96'(0));
    drive_beat(64'hC002, 1'b1);
    chk("withdraw_eop_ack", 96'(freeze_ack), 96'(1));
    pr_freeze = 1'b0;
    tick(1);

    // Reset in the middle of ABORT: no synthetic beat escapes
    drive_beat(64'hD001, 1'b0);
    pr_freeze = 1'b1;
    src_if.tready = 1'b0;
    tick(17);
    chk("pre_rst_abort", 96'(src_if.tvalid), 96'(1));
    rst = 1'b1;
    snk_if.tvalid = 1'b1;
    src_if.tready = 1'b1;
    #1;
    chk("rst_abort_tvalid", 96'(src_if.tvalid), 96'(0));
    chk("rst_abort_tready", 96'(snk_if.tready), 96'(0));
    chk("rst_abort_ack", 96'(freeze_ack), 96'(0));
    tick(2);
    rst = 1'b0;
    pr_freeze = 1'b0;
    snk_if.tvalid = 1'b0;
    exp_drop = 16'd0;
    tick(1);
    chk("rst_clears_timeout", 96'(eop_timeout), 96'(0));
    chk("rst_clears_ack", 96'(freeze_ack), 96'(0));
    chk("rst_clears_drop", 96'(drop_cnt), 96'(exp_drop));
    pr_freeze = 1'b1;
    tick(1);
    chk("rst_clears_inpkt", 96'(freeze_ack), 96'(1));

    // Long offer while frozen
    snk_if.tvalid = 1'b1;
    if (DRAIN) begin
      tick(70000);
      exp_drop = 16'hFFFF;
    end else begin
      tick(20);
    end
    chk("drain_tready", 96'(snk_if.tready), 96'(DRAIN));
    chk("drain_tvalid", 96'(src_if.tvalid), 96'(0));
    chk("drain_cnt", 96'(drop_cnt), 96'(exp_drop));
    snk_if.tvalid = 1'b0;
    pr_freeze = 1'b0;
    tick(2);
    chk("sb_empty", 96'(exp_q.size()), 96'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
